ram_arbiter: RTL and testbench

Sequences the single byte-wide RAM port between two requesters: instruction fetch, which needs a 32-bit word, and the bus unit, which executes the movzbq/movb byte loads and stores. Fetch is serviced as four sequential byte reads, assembled big-endian so that the opcode byte lands in bits 31:24. Data accesses take priority. The block sits between the control unit / bus unit and the RAM macro.

---
 rtl/ram_arbiter_pkg.sv | 21 ++
 rtl/ram_arbiter_if.sv | 31 +++
 rtl/ram_arbiter_word_assembler.sv | 24 ++
 rtl/ram_arbiter.sv | 115 +++++++++++
 tb/tb_ram_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared types and constants for the byte-RAM arbiter
package pkg_arb;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 3'd0;
  localparam arb_state_t ST_FETCH   = 3'd1;
  localparam arb_state_t ST_F_LAST  = 3'd2;
  localparam arb_state_t ST_D_READ  = 3'd3;
  localparam arb_state_t ST_D_LAST  = 3'd4;
  localparam arb_state_t ST_D_WRITE = 3'd5;
  localparam arb_state_t ST_ACK     = 3'd6;

  localparam int ARB_FETCH_BYTES = 4;

  typedef enum logic {
    ARB_FETCH = 1'b0,
    ARB_DATA  = 1'b1
  } arb_req_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - requester handshakes and RAM macro port
interface ram_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic [31:0]       fetch_data;

  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [7:0]        data_wdata;
  logic              data_ack;
  logic [7:0]        data_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport slave (
    input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, ram_rdata,
    output fetch_ack, fetch_data, data_ack, data_rdata, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata, ram_rdata,
    input  fetch_ack, fetch_data, data_ack, data_rdata, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/ram_arbiter_word_assembler.sv
// rtl/ram_arbiter_word_assembler.sv - 32-bit left-shift register for fetch words
// Bytes enter at the bottom, so the first byte read ends up in bits 31:24.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word
);

  logic [31:0] r_word;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_word <= '0;
    end else if (i_shift) begin
      r_word <= {r_word[23:0], i_byte};
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one byte-wide RAM port between fetch and data
// Data requests win ties; a fetch is four byte reads and is never preempted.
module ram_arbiter
  import pkg_arb::*;
#(
  parameter int ADDR_W = 16
) (
  input logic           clk,
  input logic           rst,
  ram_arbiter_if.slave  bus
);

  localparam int                CNT_W    = $clog2(ARB_FETCH_BYTES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ARB_FETCH_BYTES - 1);

  arb_state_t        r_state;
  arb_req_t          r_gnt;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_wdata;
  logic [7:0]        r_data_rdata;
  logic [31:0]       r_fetch_hold;

  logic [31:0]       w_word;
  logic              w_shift;
  logic              w_clr;
  logic              w_ack;
  logic              w_fetch_ack;
  logic [ADDR_W-1:0] w_ram_addr;

  // The byte addressed in FETCH with cnt=k arrives one cycle later, hence cnt>0 and F_LAST.
  assign w_shift = ((r_state == ST_FETCH) && (r_cnt != '0)) || (r_state == ST_F_LAST);
  assign w_clr   = (r_state == ST_IDLE) && !bus.data_req && bus.fetch_req;

  word_assembler u_word_assembler (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_shift (w_shift),
    .i_byte  (bus.ram_rdata),
    .o_word  (w_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_gnt        <= ARB_FETCH;
      r_base       <= '0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_wdata      <= '0;
      r_data_rdata <= '0;
      r_fetch_hold <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.data_req) begin
            r_gnt   <= ARB_DATA;
            r_addr  <= bus.data_addr;
            r_wdata <= bus.data_wdata;
            r_state <= bus.data_we ? ST_D_WRITE : ST_D_READ;
          end else if (bus.fetch_req) begin
            r_gnt   <= ARB_FETCH;
            r_base  <= bus.fetch_addr;
            r_cnt   <= '0;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_F_LAST;
          end
        end
        ST_F_LAST:  r_state <= ST_ACK;
        ST_D_READ:  r_state <= ST_D_LAST;
        ST_D_LAST: begin
          r_data_rdata <= bus.ram_rdata;
          r_state      <= ST_ACK;
        end
        ST_D_WRITE: r_state <= ST_ACK;
        ST_ACK: begin
          if (r_gnt == ARB_FETCH) begin
            r_fetch_hold <= w_word;
          end
          r_state <= ST_IDLE;
        end
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ram_addr = '0;
    case (r_state)
      ST_FETCH:              w_ram_addr = r_base + ADDR_W'(r_cnt);
      ST_D_READ, ST_D_WRITE: w_ram_addr = r_addr;
      default:               w_ram_addr = '0;
    endcase
  end

  assign w_ack       = (r_state == ST_ACK) && !rst;
  assign w_fetch_ack = w_ack && (r_gnt == ARB_FETCH);

  assign bus.fetch_ack  = w_fetch_ack;
  assign bus.data_ack   = w_ack && (r_gnt == ARB_DATA);
  // The finished word sits in the assembler during ACK and is held afterwards.
  assign bus.fetch_data = w_fetch_ack ? w_word : r_fetch_hold;
  assign bus.data_rdata = r_data_rdata;
  assign bus.ram_addr   = w_ram_addr;
  assign bus.ram_we     = (r_state == ST_D_WRITE) && !rst;
  assign bus.ram_wdata  = r_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized self-checking bench for ram_arbiter
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(16)) u_bus ();

  ram_arbiter #(.ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_bus)
  );

  logic [7:0]  ram_mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        bd_we   = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) ram_mem[bd_addr] <= bd_data;
    else if (u_bus.ram_we) ram_mem[u_bus.ram_addr] <= u_bus.ram_wdata;
    u_bus.ram_rdata <= ram_mem[u_bus.ram_addr];
  end

  int errors = 0;
  int checks = 0;

  logic [15:0] tr_addr  [0:31];
  logic        tr_we    [0:31];
  logic        tr_fack  [0:31];
  logic        tr_dack  [0:31];
  logic [31:0] tr_fdata [0:31];
  logic [7:0]  tr_ddata [0:31];

  task automatic poke(input logic [15:0] a, input logic [7:0] v);
    bd_addr = a;
    bd_data = v;
    bd_we   = 1'b1;
    ref_mem[a] = v;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic poke_word(input logic [15:0] a, input logic [31:0] w);
    poke(a,          w[31:24]);
    poke(a + 16'd1,  w[23:16]);
    poke(a + 16'd2,  w[15:8]);
    poke(a + 16'd3,  w[7:0]);
  endtask

  function automatic logic [31:0] ref_word(input logic [15:0] a);
    logic [15:0] a1, a2, a3;
    a1 = a + 16'd1;
    a2 = a + 16'd2;
    a3 = a + 16'd3;
    return {ref_mem[a], ref_mem[a1], ref_mem[a2], ref_mem[a3]};
  endfunction

  // Current cycle is C0; records C1..Cn and drops each request on its ack.
  task automatic run(input int n, input int inj_at);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (k == inj_at) u_bus.data_req = 1'b1;
      tr_addr[k]  = u_bus.ram_addr;
      tr_we[k]    = u_bus.ram_we;
      tr_fack[k]  = u_bus.fetch_ack;
      tr_dack[k]  = u_bus.data_ack;
      tr_fdata[k] = u_bus.fetch_data;
      tr_ddata[k] = u_bus.data_rdata;
      if (u_bus.fetch_ack) u_bus.fetch_req = 1'b0;
      if (u_bus.data_ack)  u_bus.data_req  = 1'b0;
    end
  endtask

  function automatic logic [31:0] mask_of(input int sel, input int n);
    logic [31:0] m;
    m = '0;
    for (int k = 1; k <= n; k++) begin
      case (sel)
        0: m[k] = tr_fack[k];
        1: m[k] = tr_dack[k];
        default: m[k] = tr_we[k];
      endcase
    end
    return m;
  endfunction

  task automatic test_reset();
    u_bus.fetch_req = 0; u_bus.fetch_addr = '0;
    u_bus.data_req = 0; u_bus.data_we = 0; u_bus.data_addr = '0; u_bus.data_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({u_bus.fetch_ack, u_bus.data_ack, u_bus.ram_we} !== 3'b000)
      $display("FAIL reset_ctrl: got %b expected 000", {u_bus.fetch_ack, u_bus.data_ack, u_bus.ram_we});
    checks++;
    if (u_bus.ram_addr !== 16'h0) $display("FAIL reset_addr: got %h expected 0000", u_bus.ram_addr);
    checks++;
    if (u_bus.fetch_data !== 32'h0) $display("FAIL reset_fdata: got %h expected 0", u_bus.fetch_data);
    checks++;
    if (u_bus.data_rdata !== 8'h0) $display("FAIL reset_rdata: got %h expected 0", u_bus.data_rdata);
    errors += (({u_bus.fetch_ack, u_bus.data_ack, u_bus.ram_we} !== 3'b000) ? 1 : 0)
            + ((u_bus.ram_addr !== 16'h0) ? 1 : 0)
            + ((u_bus.fetch_data !== 32'h0) ? 1 : 0)
            + ((u_bus.data_rdata !== 8'h0) ? 1 : 0);
  endtask

  task automatic check_fetch(input string nm, input logic [15:0] fa, input int c0,
                             input logic [31:0] exp);
    logic [15:0] ea;
    for (int i = 0; i < 4; i++) begin
      ea = fa + 16'(i);
      checks++;
      if (tr_addr[c0 + 1 + i] !== ea) begin
        errors++;
        $display("FAIL %s_addr%0d: got %h expected %h", nm, i, tr_addr[c0 + 1 + i], ea);
      end
    end
    checks++;
    if (tr_fdata[c0 + 6] !== exp) begin
      errors++;
      $display("FAIL %s_data: got %h expected %h", nm, tr_fdata[c0 + 6], exp);
    end
  endtask

  task automatic test_fetch();
    logic [15:0] fa;
    logic [31:0] exp;
    for (int t = 0; t < 6; t++) begin
      fa = (t == 0) ? 16'h0100 : 16'($urandom);
      poke_word(fa, (t == 0) ? 32'h102A0005 : $urandom);
      exp = ref_word(fa);
      u_bus.fetch_addr = fa;
      u_bus.fetch_req  = 1'b1;
      run(10, 0);
      check_fetch("fetch", fa, 0, exp);
      checks++;
      if (mask_of(0, 10) !== 32'h1 << 6) begin
        errors++;
        $display("FAIL fetch_ack: got %h expected %h", mask_of(0, 10), 32'h1 << 6);
      end
      checks++;
      if ((mask_of(1, 10) | mask_of(2, 10)) !== 32'h0) begin
        errors++;
        $display("FAIL fetch_side: got %h expected 0", mask_of(1, 10) | mask_of(2, 10));
      end
      checks++;
      if (tr_fdata[10] !== exp) begin
        errors++;
        $display("FAIL fetch_hold: got %h expected %h", tr_fdata[10], exp);
      end
    end
  endtask

  task automatic test_store_load();
    logic [15:0] a;
    logic        we;
    logic [7:0]  wd;
    int          ea;
    for (int i = 0; i < 16; i++) poke(16'h0040 + 16'(i), 8'($urandom));
    for (int t = 0; t < 12; t++) begin
      if (t < 2) begin
        a = 16'h0040; we = (t == 0); wd = 8'hA5;
      end else begin
        a = 16'h0040 + 16'($urandom_range(0, 15)); we = 1'($urandom); wd = 8'($urandom);
      end
      u_bus.data_addr = a; u_bus.data_we = we; u_bus.data_wdata = wd; u_bus.data_req = 1'b1;
      run(6, 0);
      ea = we ? 2 : 3;
      checks++;
      if (mask_of(1, 6) !== 32'h1 << ea) begin
        errors++;
        $display("FAIL sl_ack: got %h expected %h", mask_of(1, 6), 32'h1 << ea);
      end
      checks++;
      if (mask_of(2, 6) !== (we ? 32'h2 : 32'h0)) begin
        errors++;
        $display("FAIL sl_we: got %h expected %h", mask_of(2, 6), we ? 32'h2 : 32'h0);
      end
      checks++;
      if (tr_addr[1] !== a) begin
        errors++;
        $display("FAIL sl_addr: got %h expected %h", tr_addr[1], a);
      end
      if (we) ref_mem[a] = wd;
      else begin
        checks++;
        if (tr_ddata[3] !== ref_mem[a] || tr_ddata[6] !== ref_mem[a]) begin
          errors++;
          $display("FAIL sl_rdata: got %h expected %h", tr_ddata[3], ref_mem[a]);
        end
      end
    end
  endtask

  task automatic test_tie();
    logic [15:0] a, fa;
    logic [7:0]  wd;
    logic [31:0] exp;
    int          d;
    for (int w = 0; w < 2; w++) begin
      a  = 16'h0040 + 16'($urandom_range(0, 15));
      wd = 8'($urandom);
      fa = 16'($urandom);
      poke_word(fa, $urandom);
      u_bus.data_addr = a; u_bus.data_we = (w == 1); u_bus.data_wdata = wd;
      u_bus.fetch_addr = fa;
      u_bus.data_req = 1'b1; u_bus.fetch_req = 1'b1;
      run(14, 0);
      d = (w == 1) ? 2 : 3;
      if (w == 0) begin
        checks++;
        if (tr_ddata[d] !== ref_mem[a]) begin
          errors++;
          $display("FAIL tie_rdata: got %h expected %h", tr_ddata[d], ref_mem[a]);
        end
      end else ref_mem[a] = wd;
      exp = ref_word(fa);
      checks++;
      if (mask_of(1, 14) !== 32'h1 << d) begin
        errors++;
        $display("FAIL tie_dack: got %h expected %h", mask_of(1, 14), 32'h1 << d);
      end
      checks++;
      if (mask_of(0, 14) !== 32'h1 << (d + 7)) begin
        errors++;
        $display("FAIL tie_fack: got %h expected %h", mask_of(0, 14), 32'h1 << (d + 7));
      end
      check_fetch("tie", fa, d + 1, exp);
    end
  endtask

  task automatic test_data_during_fetch();
    logic [15:0] a, fa;
    logic [7:0]  wd;
    logic [31:0] exp;
    logic [7:0]  exp_rd;
    int          dk;
    for (int w = 0; w < 2; w++) begin
      a  = 16'h0040 + 16'($urandom_range(0, 15));
      wd = 8'($urandom);
      fa = 16'($urandom);
      poke_word(fa, $urandom);
      exp    = ref_word(fa);
      exp_rd = ref_mem[a];
      u_bus.data_addr = a; u_bus.data_we = (w == 1); u_bus.data_wdata = wd;
      u_bus.fetch_addr = fa; u_bus.fetch_req = 1'b1;
      run(14, 2);
      dk = (w == 1) ? 9 : 10;
      check_fetch("dpf", fa, 0, exp);
      checks++;
      if (mask_of(0, 14) !== 32'h1 << 6) begin
        errors++;
        $display("FAIL dpf_fack: got %h expected %h", mask_of(0, 14), 32'h1 << 6);
      end
      checks++;
      if (mask_of(1, 14) !== 32'h1 << dk) begin
        errors++;
        $display("FAIL dpf_dack: got %h expected %h", mask_of(1, 14), 32'h1 << dk);
      end
      checks++;
      if (tr_addr[8] !== a || mask_of(2, 14) !== ((w == 1) ? 32'h1 << 8 : 32'h0)) begin
        errors++;
        $display("FAIL dpf_daccess: got addr %h we %h expected addr %h", tr_addr[8], mask_of(2, 14), a);
      end
      if (w == 1) ref_mem[a] = wd;
      else begin
        checks++;
        if (tr_ddata[dk] !== exp_rd) begin
          errors++;
          $display("FAIL dpf_rdata: got %h expected %h", tr_ddata[dk], exp_rd);
        end
      end
    end
  endtask

  task automatic test_wrap();
    poke_word(16'hFFFE, 32'hABCDEF12);
    u_bus.fetch_addr = 16'hFFFE;
    u_bus.fetch_req  = 1'b1;
    run(10, 0);
    check_fetch("wrap", 16'hFFFE, 0, 32'hABCDEF12);
  endtask

  task automatic test_reset_mid();
    poke(16'h0050, 8'h3C);
    u_bus.data_addr = 16'h0050; u_bus.data_we = 1'b1; u_bus.data_wdata = 8'hC3;
    u_bus.data_req  = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    u_bus.data_req = 1'b0;
    #1;
    checks++;
    if ({u_bus.ram_we, u_bus.data_ack} !== 2'b00) begin
      errors++;
      $display("FAIL rmid_we: got %b expected 00", {u_bus.ram_we, u_bus.data_ack});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({u_bus.fetch_ack, u_bus.data_ack, u_bus.ram_we} !== 3'b000 || u_bus.ram_addr !== 16'h0
        || u_bus.fetch_data !== 32'h0 || u_bus.data_rdata !== 8'h0) begin
      errors++;
      $display("FAIL rmid_outs: got fdata %h rdata %h addr %h expected all zero",
               u_bus.fetch_data, u_bus.data_rdata, u_bus.ram_addr);
    end
    run(4, 0);
    checks++;
    if ((mask_of(0, 4) | mask_of(1, 4) | mask_of(2, 4)) !== 32'h0) begin
      errors++;
      $display("FAIL rmid_quiet: got %h expected 0", mask_of(0, 4) | mask_of(1, 4) | mask_of(2, 4));
    end
    u_bus.data_we = 1'b0; u_bus.data_req = 1'b1;
    run(6, 0);
    checks++;
    if (mask_of(1, 6) !== 32'h1 << 3 || tr_ddata[3] !== ref_mem[16'h0050]) begin
      errors++;
      $display("FAIL rmid_reload: got ack %h data %h expected ack %h data %h",
               mask_of(1, 6), tr_ddata[3], 32'h1 << 3, ref_mem[16'h0050]);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_load();
    test_tie();
    test_data_during_fetch();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
